// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave arbiter for the peripheral bus.
// Serialises read/write transactions from m0 and m1 with round-robin
// fairness, holds the slave strobes until completion and returns a
// one-cycle completion pulse to the owning master.
// Optional read timeout is compiled in by defining ARB_TIMEOUT_EN; without
// it a read waits for s_rd_valid indefinitely and timeout is tied low.
module bus_arbiter #(
  parameter int unsigned    W        = 32,
  parameter int unsigned    AW       = 16,
  parameter int unsigned    TIMEOUT  = 255,
  parameter logic [W-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW-1:0] m0_addr,
  input  logic          m0_ren,
  input  logic          m0_wen,
  input  logic [W-1:0]  m0_wdata,
  input  logic [3:0]    m0_wmask,
  output logic [W-1:0]  m0_rdata,
  output logic          m0_rd_valid,
  output logic          m0_wack,

  input  logic [AW-1:0] m1_addr,
  input  logic          m1_ren,
  input  logic          m1_wen,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m1_wmask,
  output logic [W-1:0]  m1_rdata,
  output logic          m1_rd_valid,
  output logic          m1_wack,

  output logic [AW-1:0] s_addr,
  output logic          s_ren,
  output logic          s_wen,
  output logic [W-1:0]  s_wdata,
  output logic [3:0]    s_wmask,
  input  logic [W-1:0]  s_rdata,
  input  logic          s_rd_valid,

  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  arbState_e       r_state;
  arbState_e       w_nextState;

  logic            r_owner;
  logic            r_lastGrant;
  logic            r_isRead;
  logic [AW-1:0]   r_addr;
  logic [W-1:0]    r_wdata;
  logic [3:0]      r_wmask;
  logic [W-1:0]    r_m0Rdata;
  logic [W-1:0]    r_m1Rdata;

  logic            w_req0;
  logic            w_req1;
  logic            w_grant;
  logic            w_winner;
  logic            w_winWrite;
  logic            w_capture;
  logic            w_countHit;
  logic [W-1:0]    w_rdataIn;

  // A master is requesting whenever either strobe is high; a write strobe
  // takes precedence over a read strobe from the same master.
  always_comb begin
    w_req0 = m0_ren | m0_wen;
    w_req1 = m1_ren | m1_wen;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_count;
  logic             r_timedOut;

  // The final READ cycle is the one in which the counter shows TIMEOUT-1.
  assign w_countHit = (r_count == CNT_W'(TIMEOUT - 1));

  // On expiry the owner receives the error pattern instead of slave data.
  assign w_rdataIn  = s_rd_valid ? s_rdata : ERR_DATA;

  // Counts READ cycles; cleared everywhere else so it starts at zero on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_timedOut <= 1'b0;
    end else begin
      if (r_state == READ) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= '0;
      end
      if (w_grant) begin
        r_timedOut <= 1'b0;
      end else if ((r_state == READ) && !s_rd_valid && w_countHit) begin
        r_timedOut <= 1'b1;
      end
    end
  end

  assign timeout = (r_state == DONE) && r_timedOut;
`else
  logic w_unusedParams;

  assign w_unusedParams = ^{ERR_DATA, TIMEOUT};
  assign w_countHit     = 1'b0;
  assign w_rdataIn      = s_rdata;
  assign timeout        = 1'b0;
`endif

  // State register; reset returns to IDLE even in the middle of a transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state, arbitration and strobe/pulse generation.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_winner    = 1'b0;
    w_winWrite  = 1'b0;
    w_capture   = 1'b0;
    s_ren       = 1'b0;
    s_wen       = 1'b0;
    m0_rd_valid = 1'b0;
    m1_rd_valid = 1'b0;
    m0_wack     = 1'b0;
    m1_wack     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 || w_req1) begin
          w_grant = 1'b1;
          if (w_req0 && w_req1) begin
            w_winner = ~r_lastGrant;
          end else begin
            w_winner = w_req1;
          end
          w_winWrite  = w_winner ? m1_wen : m0_wen;
          w_nextState = w_winWrite ? WRITE : READ;
        end
      end
      READ: begin
        s_ren = 1'b1;
        if (s_rd_valid || w_countHit) begin
          w_capture   = 1'b1;
          w_nextState = DONE;
        end
      end
      WRITE: begin
        s_wen       = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        w_nextState = IDLE;
        if (r_isRead) begin
          if (r_owner) begin
            m1_rd_valid = 1'b1;
          end else begin
            m0_rd_valid = 1'b1;
          end
        end else begin
          if (r_owner) begin
            m1_wack = 1'b1;
          end else begin
            m0_wack = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Latches the winner's transaction on grant and remembers it for fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_isRead    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else if (w_grant) begin
      r_owner     <= w_winner;
      r_lastGrant <= w_winner;
      r_isRead    <= ~w_winWrite;
      r_addr      <= w_winner ? m1_addr  : m0_addr;
      r_wdata     <= w_winner ? m1_wdata : m0_wdata;
      r_wmask     <= w_winner ? m1_wmask : m0_wmask;
    end
  end

  // Per-master read data holds until that master's next read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m0Rdata <= '0;
      r_m1Rdata <= '0;
    end else if (w_capture) begin
      if (r_owner) begin
        r_m1Rdata <= w_rdataIn;
      end else begin
        r_m0Rdata <= w_rdataIn;
      end
    end
  end

  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign s_wmask  = r_wmask;
  assign m0_rdata = r_m0Rdata;
  assign m1_rdata = r_m1Rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: drives two randomly behaving masters and a slave with
// random response latency into bus_arbiter and compares every output, every
// cycle, against a transaction-level schedule of what the bus should show.
module tb_bus_arbiter;

  localparam int          W    = 32;
  localparam int          AW   = 16;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERR  = 32'hDEADBEEF;
  localparam int          NCYC = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr,  m1_addr;
  logic          m0_ren,   m1_ren;
  logic          m0_wen,   m1_wen;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          m0_rd_valid, m1_rd_valid;
  logic          m0_wack,  m1_wack;
  logic [AW-1:0] s_addr;
  logic          s_ren, s_wen;
  logic [W-1:0]  s_wdata;
  logic [3:0]    s_wmask;
  logic [W-1:0]  s_rdata;
  logic          s_rd_valid;
  logic          timeout;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  bus_arbiter #(
    .W        (W),
    .AW       (AW),
    .TIMEOUT  (TMO),
    .ERR_DATA (ERR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_addr     (m0_addr),
    .m0_ren      (m0_ren),
    .m0_wen      (m0_wen),
    .m0_wdata    (m0_wdata),
    .m0_wmask    (m0_wmask),
    .m0_rdata    (m0_rdata),
    .m0_rd_valid (m0_rd_valid),
    .m0_wack     (m0_wack),
    .m1_addr     (m1_addr),
    .m1_ren      (m1_ren),
    .m1_wen      (m1_wen),
    .m1_wdata    (m1_wdata),
    .m1_wmask    (m1_wmask),
    .m1_rdata    (m1_rdata),
    .m1_rd_valid (m1_rd_valid),
    .m1_wack     (m1_wack),
    .s_addr      (s_addr),
    .s_ren       (s_ren),
    .s_wen       (s_wen),
    .s_wdata     (s_wdata),
    .s_wmask     (s_wmask),
    .s_rdata     (s_rdata),
    .s_rd_valid  (s_rd_valid),
    .timeout     (timeout)
  );

  int checkCount = 0;
  int failCount  = 0;
  int now        = 0;

  bit            mActive[2];
  bit            mWrite[2];
  bit            mBoth[2];
  bit            mDropNext[2];
  int            mGap[2];
  logic [AW-1:0] mAddr[2];
  logic [W-1:0]  mData[2];
  logic [3:0]    mMask[2];

  bit            txnValid;
  bit            txnOwner;
  bit            txnRead;
  bit            txnTimedOut;
  int            txnGrant;
  int            txnLat;
  int            txnEff;
  int            txnDone;
  logic [W-1:0]  txnData;
  bit            lastGrant;

  bit            pendLatch;
  logic [AW-1:0] pendAddr;
  logic [W-1:0]  pendWdata;
  logic [3:0]    pendWmask;

  logic [W-1:0]  expRdata[2];
  logic [AW-1:0] expAddr;
  logic [W-1:0]  expWdata;
  logic [3:0]    expWmask;

  bit            rstNow;
  bit            rstPrev;
  bit            slvValid;
  logic [W-1:0]  slvData;
  bit            inWindow;

  // Compares one observed value with its expected value and logs a miss.
  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, now, got, exp);
    end
  endtask

  // Puts the current master, slave and reset intentions onto the pins.
  task automatic applyStimulus();
    rst        = rstNow;
    m0_ren     = mActive[0] && (!mWrite[0] || mBoth[0]);
    m0_wen     = mActive[0] && mWrite[0];
    m0_addr    = mAddr[0];
    m0_wdata   = mData[0];
    m0_wmask   = mMask[0];
    m1_ren     = mActive[1] && (!mWrite[1] || mBoth[1]);
    m1_wen     = mActive[1] && mWrite[1];
    m1_addr    = mAddr[1];
    m1_wdata   = mData[1];
    m1_wmask   = mMask[1];
    s_rd_valid = slvValid;
    s_rdata    = slvData;
  endtask

  // A reset wipes any transaction in flight and restores the power-on view.
  task automatic modelReset();
    txnValid    = 1'b0;
    txnTimedOut = 1'b0;
    lastGrant   = 1'b1;
    pendLatch   = 1'b0;
    expRdata[0] = '0;
    expRdata[1] = '0;
    expAddr     = '0;
    expWdata    = '0;
    expWmask    = '0;
  endtask

  // A master raises a fresh request with random kind and payload.
  task automatic newRequest(input int p);
    mActive[p] = 1'b1;
    mWrite[p]  = ($urandom_range(0, 2) == 0);
    mBoth[p]   = mWrite[p] && ($urandom_range(0, 1) == 1);
    mAddr[p]   = AW'($urandom);
    mData[p]   = $urandom;
    mMask[p]   = 4'($urandom);
  endtask

  // Round-robin choice plus the resulting bus schedule for this transaction.
  task automatic grant();
    bit w;
    if (mActive[0] && mActive[1]) w = !lastGrant;
    else                          w = mActive[1];
    txnValid    = 1'b1;
    txnOwner    = w;
    txnRead     = !mWrite[w];
    txnGrant    = now;
    lastGrant   = w;
    pendLatch   = 1'b1;
    pendAddr    = mAddr[w];
    pendWdata   = mData[w];
    pendWmask   = mMask[w];
    txnTimedOut = 1'b0;
`ifdef ARB_TIMEOUT_EN
    case ($urandom_range(0, 5))
      0:       txnLat = TMO - 1;
      1:       txnLat = TMO;
      2:       txnLat = TMO + 1;
      3:       txnLat = 1000;
      default: txnLat = $urandom_range(1, 4);
    endcase
    txnEff      = (txnLat < TMO) ? txnLat : TMO;
    txnTimedOut = (txnLat > TMO);
`else
    txnLat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 5);
    txnEff = txnLat;
`endif
    txnData = ERR;
    txnDone = txnRead ? (now + txnEff + 1) : (now + 2);
  endtask

  // Main stimulus/check loop: one iteration per clock cycle.
  initial begin
    bit isDone;
    rstNow    = 1'b1;
    slvValid  = 1'b0;
    slvData   = '0;
    for (int p = 0; p < 2; p++) begin
      mActive[p]   = 1'b0;
      mWrite[p]    = 1'b0;
      mBoth[p]     = 1'b0;
      mDropNext[p] = 1'b0;
      mGap[p]      = 0;
      mAddr[p]     = '0;
      mData[p]     = '0;
      mMask[p]     = '0;
    end
    modelReset();
    applyStimulus();
    rstPrev = 1'b1;
    repeat (2) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      now = c;
      if (rstPrev) modelReset();

      for (int p = 0; p < 2; p++) begin
        if (mDropNext[p]) begin
          mActive[p]   = 1'b0;
          mDropNext[p] = 1'b0;
          mGap[p]      = $urandom_range(0, 3);
        end
        if (!mActive[p]) begin
          if (mGap[p] == 0) newRequest(p);
          else              mGap[p]--;
        end
      end

      rstNow = ($urandom_range(0, 399) == 0);
      if (txnValid && txnRead && now == txnGrant + 3 && txnEff >= 3 &&
          $urandom_range(0, 2) == 0) rstNow = 1'b1;

      if (!rstNow && !txnValid && (mActive[0] || mActive[1])) grant();

      slvData  = $urandom;
      inWindow = txnValid && txnRead && now >= txnGrant + 1 && now <= txnGrant + txnEff;
      if (inWindow) slvValid = !txnTimedOut && (now == txnGrant + txnLat);
      else          slvValid = ($urandom_range(0, 7) == 0);
      if (inWindow && slvValid) txnData = slvData;

      applyStimulus();
      isDone = txnValid && (now == txnDone);

      @(negedge clk);
      checkOutput("s_ren",       32'(s_ren),       32'(inWindow));
      checkOutput("s_wen",       32'(s_wen),       32'(txnValid && !txnRead && now == txnGrant + 1));
      checkOutput("s_addr",      32'(s_addr),      32'(expAddr));
      checkOutput("s_wdata",     s_wdata,          expWdata);
      checkOutput("s_wmask",     32'(s_wmask),     32'(expWmask));
      checkOutput("m0_rd_valid", 32'(m0_rd_valid), 32'(isDone && txnRead && !txnOwner));
      checkOutput("m1_rd_valid", 32'(m1_rd_valid), 32'(isDone && txnRead && txnOwner));
      checkOutput("m0_wack",     32'(m0_wack),     32'(isDone && !txnRead && !txnOwner));
      checkOutput("m1_wack",     32'(m1_wack),     32'(isDone && !txnRead && txnOwner));
      checkOutput("m0_rdata",    m0_rdata,         expRdata[0]);
      checkOutput("m1_rdata",    m1_rdata,         expRdata[1]);
      checkOutput("timeout",     32'(timeout),     32'(isDone && txnRead && txnTimedOut));

      if (pendLatch) begin
        expAddr   = pendAddr;
        expWdata  = pendWdata;
        expWmask  = pendWmask;
        pendLatch = 1'b0;
      end
      if (txnValid && txnRead && now == txnGrant + txnEff) expRdata[txnOwner] = txnData;
      if (isDone) begin
        mDropNext[txnOwner] = 1'b1;
        txnValid            = 1'b0;
      end
      rstPrev = rstNow;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
